// File: rtl/image_writer_pkg.sv
// Shared constants and types for the image_writer frame buffer and its Avalon register file.
package image_pkg;

  localparam int unsigned IMG_W     = 224;
  localparam int unsigned IMG_H     = 224;
  localparam int unsigned X0        = 208;
  localparam int unsigned Y0        = 128;
  localparam int unsigned NUM_WORDS = IMG_W * IMG_H / 4;
  localparam int unsigned ROW_WORDS = IMG_W / 4;
  localparam int unsigned WORD_AW   = $clog2(NUM_WORDS);

  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_PTR  = 2'd1;
  localparam logic [1:0] REG_CTRL = 2'd2;
  localparam logic [1:0] REG_FC   = 2'd3;

  localparam int unsigned CTRL_START  = 0;
  localparam int unsigned CTRL_ABORT  = 1;
  localparam int unsigned CTRL_OVL_EN = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOADING = 2'd1,
    READY   = 2'd2
  } wr_state_t;

endpackage

// File: rtl/image_writer_if.sv
// Avalon-MM register bus between the HPS (master) and image_writer (slave).
interface image_writer_if;
  logic [1:0]  addr;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output addr, output rd_en, output wr_en, output writedata, input readdata);
  modport slave  (input addr, input rd_en, input wr_en, input writedata, output readdata);
endinterface

// File: rtl/image_frame_ram.sv
// Simple dual-port frame buffer: one write port, one registered read port, old data on collision.
module image_frame_ram #(
  parameter int unsigned Depth = 12544,
  parameter int unsigned Aw    = $clog2(Depth)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [Aw-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic [Aw-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [Depth];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/image_writer.sv
// HPS-loaded 224x224 luma frame buffer replayed as a VGA overlay stream with 2-cycle latency.
// Build with IMAGE_WRITER_BORDER_EN to paint the window perimeter with BORDER_VAL.
module image_writer
  import image_pkg::*;
#(
  parameter logic [7:0] BORDER_VAL = 8'hFF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  image_writer_if.slave        bus,
  input  logic [10:0]          pix_x,
  input  logic [10:0]          pix_y,
  input  logic                 pix_valid,
  output logic                 ovl_valid,
  output logic                 ovl_hit,
  output logic [7:0]           ovl_pixel
);

  wr_state_t          r_state, w_state_nxt;
  logic [15:0]        r_wr_ptr, w_wr_ptr_nxt;
  logic               r_err, w_err_nxt;
  logic               r_ovl_en, w_ovl_en_nxt;
  logic [31:0]        r_frame_count, w_frame_count_nxt;
  logic               w_ram_we;
  logic [31:0]        w_ram_rdata;

  // Register-file next state, including the load FSM.
  always_comb begin
    w_state_nxt       = r_state;
    w_wr_ptr_nxt      = r_wr_ptr;
    w_err_nxt         = r_err;
    w_ovl_en_nxt      = r_ovl_en;
    w_frame_count_nxt = r_frame_count;
    w_ram_we          = 1'b0;
    if (bus.wr_en) begin
      case (bus.addr)
        REG_DATA: begin
          if (r_state == LOADING) begin
            w_ram_we = 1'b1;
            if (r_wr_ptr == 16'(NUM_WORDS - 1)) begin
              w_state_nxt       = READY;
              w_frame_count_nxt = r_frame_count + 32'd1;
              w_wr_ptr_nxt      = 16'd0;
            end else begin
              w_wr_ptr_nxt = r_wr_ptr + 16'd1;
            end
          end else begin
            w_err_nxt = 1'b1;
          end
        end
        REG_PTR: begin
          if (bus.writedata[15:0] < 16'(NUM_WORDS)) w_wr_ptr_nxt = bus.writedata[15:0];
          else                                      w_err_nxt    = 1'b1;
        end
        REG_CTRL: begin
          w_ovl_en_nxt = bus.writedata[CTRL_OVL_EN];
          if (bus.writedata[CTRL_START]) begin
            w_state_nxt  = LOADING;
            w_wr_ptr_nxt = 16'd0;
            w_err_nxt    = 1'b0;
          end else if (bus.writedata[CTRL_ABORT]) begin
            w_state_nxt = IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_wr_ptr      <= 16'd0;
      r_err         <= 1'b0;
      r_ovl_en      <= 1'b0;
      r_frame_count <= 32'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_wr_ptr      <= w_wr_ptr_nxt;
      r_err         <= w_err_nxt;
      r_ovl_en      <= w_ovl_en_nxt;
      r_frame_count <= w_frame_count_nxt;
    end
  end

  always_comb begin
    bus.readdata = 32'd0;
    if (bus.rd_en) begin
      case (bus.addr)
        REG_DATA: bus.readdata = {27'd0, r_err, r_ovl_en, r_state, 1'b0};
        REG_PTR:  bus.readdata = {16'd0, r_wr_ptr};
        REG_CTRL: bus.readdata = {29'd0, r_ovl_en, 2'b00};
        default:  bus.readdata = r_frame_count;
      endcase
    end
  end

  // S1: window test and word address; X0 is a multiple of 4 so columns index words directly.
  logic               w_in_box;
  logic [10:0]        w_dy;
  logic [8:0]         w_col;
  logic [WORD_AW-1:0] w_lin;
  logic               r_s1_valid, r_s1_hit;
  logic [WORD_AW-1:0] r_s1_waddr;
  logic [1:0]         r_s1_sel, r_s2_sel;

  assign w_in_box = (pix_x >= 11'(X0)) && (pix_x < 11'(X0 + IMG_W)) &&
                    (pix_y >= 11'(Y0)) && (pix_y < 11'(Y0 + IMG_H));
  assign w_dy     = pix_y - 11'(Y0);
  assign w_col    = pix_x[10:2] - 9'(X0 / 4);
  assign w_lin    = WORD_AW'(ROW_WORDS) * WORD_AW'(w_dy) + WORD_AW'(w_col);

  always_ff @(posedge clk) begin
    r_s1_waddr <= w_lin;
    r_s1_sel   <= pix_x[1:0];
    r_s2_sel   <= r_s1_sel;
  end

`ifdef IMAGE_WRITER_BORDER_EN
  logic w_on_border;
  logic r_s1_border, r_s2_border;

  assign w_on_border = pix_valid && r_ovl_en && w_in_box &&
                       ((pix_x == 11'(X0)) || (pix_x == 11'(X0 + IMG_W - 1)) ||
                        (pix_y == 11'(Y0)) || (pix_y == 11'(Y0 + IMG_H - 1)));
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_s1_valid <= 1'b0;
      r_s1_hit   <= 1'b0;
      ovl_valid  <= 1'b0;
      ovl_hit    <= 1'b0;
`ifdef IMAGE_WRITER_BORDER_EN
      r_s1_border <= 1'b0;
      r_s2_border <= 1'b0;
`endif
    end else begin
      r_s1_valid <= pix_valid;
      r_s1_hit   <= pix_valid && w_in_box && (r_state == READY) && r_ovl_en;
      ovl_valid  <= r_s1_valid;
`ifdef IMAGE_WRITER_BORDER_EN
      r_s1_border <= w_on_border;
      r_s2_border <= r_s1_border;
      ovl_hit     <= r_s1_hit || r_s1_border;
`else
      ovl_hit     <= r_s1_hit;
`endif
    end
  end

  image_frame_ram #(
    .Depth (NUM_WORDS),
    .Aw    (WORD_AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_waddr (r_wr_ptr[WORD_AW-1:0]),
    .i_wdata (bus.writedata),
    .i_raddr (r_s1_waddr),
    .o_rdata (w_ram_rdata)
  );

  // S2: byte mux on the registered RAM word.
  logic [7:0] w_byte;
  always_comb begin
    case (r_s2_sel)
      2'd0:    w_byte = w_ram_rdata[7:0];
      2'd1:    w_byte = w_ram_rdata[15:8];
      2'd2:    w_byte = w_ram_rdata[23:16];
      default: w_byte = w_ram_rdata[31:24];
    endcase
    ovl_pixel = 8'd0;
    if (ovl_hit) ovl_pixel = w_byte;
`ifdef IMAGE_WRITER_BORDER_EN
    if (r_s2_border) ovl_pixel = BORDER_VAL;
`endif
  end

endmodule

// File: tb/tb_image_writer.sv
// Directed, table-driven bench for image_writer: register map, full load, overlay replay, errors.
module tb_image_writer;

`ifdef IMAGE_WRITER_BORDER_EN
  localparam bit Border = 1'b1;
`else
  localparam bit Border = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [10:0] pix_x, pix_y;
  logic        pix_valid;
  logic        ovl_valid, ovl_hit;
  logic [7:0]  ovl_pixel;

  int n_total = 0;
  int n_bad   = 0;

  image_writer_if u_bus ();

  image_writer u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (u_bus),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_valid (pix_valid),
    .ovl_valid (ovl_valid),
    .ovl_hit   (ovl_hit),
    .ovl_pixel (ovl_pixel)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         x;
    int         y;
    bit         v;
    bit         ev;
    bit         eh;
    logic [7:0] ep;
  } pix_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    u_bus.addr      = a;
    u_bus.writedata = d;
    u_bus.wr_en     = 1'b1;
    @(negedge clk);
    u_bus.wr_en     = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [1:0] a, input logic [31:0] exp);
    @(negedge clk);
    u_bus.addr  = a;
    u_bus.rd_en = 1'b1;
    #1;
    check(name, u_bus.readdata, exp);
    u_bus.rd_en = 1'b0;
  endtask

  task automatic pix_check(input string name, input pix_vec_t t);
    @(negedge clk);
    pix_x     = 11'(t.x);
    pix_y     = 11'(t.y);
    pix_valid = t.v;
    @(negedge clk);
    pix_valid = 1'b0;
    @(negedge clk);
    check({name, ".valid"}, {31'd0, ovl_valid}, {31'd0, t.ev});
    check({name, ".hit"},   {31'd0, ovl_hit},   {31'd0, t.eh});
    check({name, ".pixel"}, {24'd0, ovl_pixel}, {24'd0, t.ep});
  endtask

  function automatic logic [31:0] pattern(input int w);
    logic [7:0] b0;
    b0 = 8'(4 * w);
    return {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0};
  endfunction

  pix_vec_t tbl[9];
  pix_vec_t hv;

  initial begin
    tbl[0] = '{208, 128, 1, 1, 1, Border ? 8'hFF : 8'h00};
    tbl[1] = '{211, 128, 1, 1, 1, Border ? 8'hFF : 8'h03};
    tbl[2] = '{209, 129, 1, 1, 1, 8'hE1};
    tbl[3] = '{207, 128, 1, 1, 0, 8'h00};
    tbl[4] = '{432, 351, 1, 1, 0, 8'h00};
    tbl[5] = '{431, 352, 1, 1, 0, 8'h00};
    tbl[6] = '{431, 351, 1, 1, 1, 8'hFF};
    tbl[7] = '{300, 200, 1, 1, 1, 8'h5C};
    tbl[8] = '{300, 200, 0, 0, 0, 8'h00};

    u_bus.addr = 2'd0; u_bus.rd_en = 1'b0; u_bus.wr_en = 1'b0; u_bus.writedata = 32'd0;
    pix_x = 11'd0; pix_y = 11'd0; pix_valid = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Reset state
    rd_check("rst_status", 2'd0, 32'h0);
    rd_check("rst_fc", 2'd3, 32'h0);
    rd_check("rst_ptr", 2'd1, 32'h0);
    #1 check("rd_idle_zero", u_bus.readdata, 32'h0);
    hv = '{300, 200, 1, 1, 0, 8'h00};
    pix_check("rst_pix", hv);

    // Full frame load
    wr(2'd2, 32'd5);
    rd_check("load_status", 2'd0, 32'h0A);
    for (int w = 0; w < 12544; w++) wr(2'd0, pattern(w));
    rd_check("ready_status", 2'd0, 32'h0C);
    rd_check("ready_fc", 2'd3, 32'h1);
    rd_check("ready_ptr", 2'd1, 32'h0);
    rd_check("ready_ctrl", 2'd2, 32'h4);

    for (int i = 0; i < 9; i++) pix_check($sformatf("vec%0d", i), tbl[i]);

    // Errors: DATA outside LOADING leaves RAM alone; bad PTR ignored
    wr(2'd1, 32'd113);
    rd_check("ptr_set", 2'd1, 32'd113);
    wr(2'd0, 32'hDEADBEEF);
    rd_check("data_ready_err", 2'd0, 32'h1C);
    rd_check("data_ready_ptr", 2'd1, 32'd113);
    hv = '{212, 130, 1, 1, 1, 8'hC4};
    pix_check("ram_unchanged", hv);
    wr(2'd1, 32'd12544);
    rd_check("bad_ptr", 2'd1, 32'd113);
    wr(2'd2, 32'd5);
    rd_check("start_clr_err", 2'd0, 32'h0A);
    rd_check("start_ptr", 2'd1, 32'd0);
    hv = '{212, 130, 1, 1, 0, 8'h00};
    pix_check("loading_blank", hv);
    wr(2'd2, 32'd6);
    rd_check("abort_status", 2'd0, 32'h08);
    wr(2'd0, 32'h12345678);
    rd_check("data_idle_err", 2'd0, 32'h18);
    rd_check("fc_kept", 2'd3, 32'h1);

    // Reset mid-load
    wr(2'd2, 32'd5);
    for (int w = 0; w < 5000; w++) wr(2'd0, pattern(w));
    rd_check("partial_ptr", 2'd1, 32'd5000);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    rd_check("midrst_status", 2'd0, 32'h0);
    rd_check("midrst_ptr", 2'd1, 32'h0);
    rd_check("midrst_fc", 2'd3, 32'h0);
    wr(2'd2, 32'd3);
    rd_check("start_wins", 2'd0, 32'h02);

    // Perimeter in IDLE with overlay enabled
    wr(2'd2, 32'd6);
    rd_check("idle_ovl", 2'd0, 32'h08);
    hv = '{208, 200, 1, 1, Border, Border ? 8'hFF : 8'h00};
    pix_check("border_left", hv);
    hv = '{250, 200, 1, 1, 0, 8'h00};
    pix_check("idle_inner", hv);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/image_writer.md
Name: image_writer

Overview:
- Return path of the capture pipeline: the HPS loads a 224x224 8-bit luma image over Avalon-MM.
- The block stores the image in an on-chip frame buffer.
- It replays the image as an overlay pixel stream, driven by synchronized VGA coordinates, inside the centred capture window (208,128)-(431,351) of the 640x480 screen.
- It lives in the 100 MHz clk domain, beside the capture block. The VGA-side consumer supplies already-synchronized coordinates.

Parameters:
- IMG_W, 224, image width in pixels (must be a multiple of 4)
- IMG_H, 224, image height in pixels
- X0, 208, screen X of the window's left column (must be a multiple of 4)
- Y0, 128, screen Y of the window's top row
- BORDER_VAL, 8'hFF, luma value used by the optional border

Ports:
- clk  in  1  system clock (100 MHz)
- reset_n  in  1  reset; synchronous, active-low
- addr  in  2  Avalon register select
- rd_en  in  1  Avalon read strobe
- wr_en  in  1  Avalon write strobe
- writedata  in  32  Avalon write data
- readdata  out  32  Avalon read data; combinational; 0 when rd_en=0
- pix_x  in  11  current screen X, clk domain
- pix_y  in  11  current screen Y, clk domain
- pix_valid  in  1  pix_x/pix_y valid this cycle
- ovl_valid  out  1  pix_valid delayed 2 cycles
- ovl_hit  out  1  delayed pixel is inside the window AND state==READY AND ovl_en
- ovl_pixel  out  8  overlay luma; 0 when ovl_hit=0

Behaviour:
- Frame buffer: IMG_W*IMG_H/4 = 12544 words of 32 bits. Pixel p sits in word p>>2, byte p[1:0] (byte 0 = bits 7:0). The buffer is not cleared by reset.
- Register map, writes:
  - addr0 DATA: store writedata at word wr_ptr, then wr_ptr+1.
  - addr1 PTR: wr_ptr <= writedata[15:0].
  - addr2 CTRL: bit0 START, bit1 ABORT, bit2 ovl_en (level, stored).
  - addr3: write ignored.
- Register map, reads:
  - addr0 STATUS = {27'b0, err, ovl_en, state[1:0], 1'b0}.
  - addr1 = {16'b0, wr_ptr}.
  - addr2 = {29'b0, ovl_en, 2'b0}.
  - addr3 = frame_count (32-bit).
- FSM states: IDLE=0, LOADING=1, READY=2.
  - START (any state): next cycle state=LOADING, wr_ptr=0, err=0.
  - ABORT: state=IDLE. If START and ABORT are set together, START wins.
  - LOADING, DATA write with wr_ptr==12543: store word, state=READY, frame_count+1, wr_ptr=0. All in the same edge.
  - DATA write while not LOADING: RAM unchanged and err<=1 (sticky until START).
  - PTR write with value >=12544: ignored, err<=1.
- Reset values: state=IDLE, wr_ptr=0, ovl_en=0, err=0, frame_count=0, ovl_valid=0, ovl_hit=0, ovl_pixel=0.
- Reset mid-load abandons the frame (state IDLE) and leaves RAM contents as written.
- Display pipeline, 2-cycle latency from pix_* to ovl_*:
  - S1 registers in_box = X0<=x<X0+IMG_W && Y0<=y<Y0+IMG_H, word address = (IMG_W/4)*(y-Y0) + ((x-X0)>>2), and byte select = x[1:0].
  - S2 is the registered RAM read plus byte mux.
  - pix_valid=0 gives ovl_valid=0, ovl_hit=0 two cycles later.
- Read-during-write to the same word returns old data.
- frame_count wraps 0xFFFFFFFF -> 0.
- The state and ovl_en used in S2 are sampled at S1, so a START mid-frame blanks the overlay 2 cycles later.

Optional Feature:
- Macro IMAGE_WRITER_BORDER_EN.
- When defined: pixels on the window perimeter (x==X0, x==X0+IMG_W-1, y==Y0, y==Y0+IMG_H-1) output BORDER_VAL with ovl_hit=1 whenever ovl_en=1, regardless of state. This shows the capture frame even while loading.
- When not defined: perimeter pixels come from the buffer like any other, and there is no extra logic.

Decomposition:
- Package image_pkg holds:
  - IMG_W, IMG_H, X0, Y0, NUM_WORDS=12544
  - register address constants REG_DATA/REG_PTR/REG_CTRL/REG_FC
  - typedef enum logic [1:0] {IDLE, LOADING, READY} wr_state_t
  - CTRL bit positions
- Sub-module image_frame_ram: simple dual-port, one clock, 32x12544, one write port, one registered read port, old-data read-during-write.

Test Plan:
- Reset, then read addr0 -> 32'h0; read addr3 -> 0. Drive pix (300,200) valid -> ovl_valid=1 after 2 cycles, ovl_hit=0, ovl_pixel=0.
- CTRL=5 (START|ovl_en), then 12544 DATA writes of {p+3,p+2,p+1,p} (byte p = pixel index mod 256):
  - after the last write, STATUS state=2 and addr3=1;
  - pix (208,128) -> ovl_pixel 0x00, hit=1;
  - pix (211,128) -> 0x03;
  - pix (209,129) -> (224+1) mod 256 = 0xE1.
- Boundary: pix (207,128), (432,351) and (431,352) -> hit=0. Pix (431,351) -> pixel 50175 mod 256 = 0xFF.
- DATA write in IDLE -> err=1 and RAM unchanged. PTR write 12544 -> wr_ptr unchanged, err=1. START clears err.
- After 5000 DATA writes, assert reset_n=0 for 1 cycle -> state IDLE, wr_ptr=0. Then CTRL=3 (START+ABORT) -> state LOADING.
- With IMAGE_WRITER_BORDER_EN, ovl_en=1, state IDLE: pix (208,200) -> hit=1, pixel 0xFF; pix (250,200) -> hit=0.
